// File: rtl/simple_phase_ctrl_pkg.sv
// Shared ISA definitions for the simple core's phase sequencer:
// sequencer state encoding, opcodes, field positions, immediate sign-extension.
package simple_isa_pkg;

   localparam int OPC_MSB = 7;
   localparam int OPC_LSB = 5;
   localparam int IMM_W   = 5;

   // Low two bits are the visible phase; HALTED aliases to phase 00.
   typedef enum logic [2:0] {
      PH_FETCH  = 3'b000,
      PH_DECODE = 3'b001,
      PH_EXEC   = 3'b010,
      PH_UPDATE = 3'b011,
      PH_HALTED = 3'b100
   } phase_e;

   typedef enum logic [2:0] {
      OP_NOP  = 3'b000,
      OP_ADD  = 3'b001,
      OP_SUB  = 3'b010,
      OP_LD   = 3'b011,
      OP_BRZ  = 3'b100,
      OP_JMP  = 3'b101,
      OP_RSV  = 3'b110,
      OP_HALT = 3'b111
   } opcode_e;

   // Sign-extend the low 'w' bits of 'raw' to 8 bits.
   function automatic logic [7:0] sext_imm(input logic [7:0] raw, input int w);
      logic signed [7:0] t;
      t = raw << (8 - w);
      return t >>> (8 - w);
   endfunction

endpackage

// File: rtl/simple_phase_ctrl_if.sv
// PC-update / handshake bundle between the phase sequencer and the core.
// master: the sequencer; slave: the core side (memory, execute, PC).
interface simple_phase_ctrl_if;
   logic       imem_valid;
   logic [7:0] instr;
   logic       ex_done;
   logic       zero_flag;
   logic [1:0] phase;
   logic [7:0] pc_incr;
   logic [7:0] ir;
   logic       halted;
   logic       wdog_err;

   modport master (
      input  imem_valid, instr, ex_done, zero_flag,
      output phase, pc_incr, ir, halted, wdog_err
   );

   modport slave (
      output imem_valid, instr, ex_done, zero_flag,
      input  phase, pc_incr, ir, halted, wdog_err
   );
endinterface

// File: rtl/simple_phase_ctrl_br_resolve.sv
// Combinational branch resolution: next PC increment and halt detect
// from the latched opcode, immediate and the ALU zero flag.
module simple_br_resolve
   import simple_isa_pkg::*;
#(
   parameter int IMM_W = 5
) (
   input  opcode_e          i_opcode,
   input  logic [IMM_W-1:0] i_imm,
   input  logic             i_zero_flag,
   output logic [7:0]       o_pc_incr,
   output logic             o_is_halt
);

   logic [7:0] w_imm_sx;

   assign w_imm_sx = sext_imm(8'(i_imm), IMM_W);

   // Sequential opcodes step by one; branches take the immediate.
   always_comb begin
      o_pc_incr = 8'd1;
      o_is_halt = 1'b0;
      case (i_opcode)
         OP_BRZ:  if (i_zero_flag) o_pc_incr = w_imm_sx;
         OP_JMP:  o_pc_incr = w_imm_sx;
         OP_HALT: o_is_halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: rtl/simple_phase_ctrl.sv
// Four-phase instruction sequencer for the simple ISA core.
// FETCH -> DECODE -> EXEC -> UPDATE, with a sticky HALTED state.
// Optional stall watchdog: define SIMPLE_PHASE_CTRL_WDOG_EN.
module simple_phase_ctrl
   import simple_isa_pkg::*;
#(
   parameter int IMM_W      = 5,
   parameter int WDOG_LIMIT = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   simple_phase_ctrl_if.master   bus
);

   phase_e     r_state;
   phase_e     w_state_nxt;
   logic [7:0] r_ir;
   logic [7:0] r_pc_incr;
   logic       w_ld_ir;
   logic       w_ld_incr;
   logic       w_stall;
   logic       w_wdog_trip;
   logic [7:0] w_incr;
   logic       w_is_halt;
   opcode_e    w_opcode;

   assign w_opcode = opcode_e'(r_ir[OPC_MSB:OPC_LSB]);

   simple_br_resolve #(.IMM_W(IMM_W)) u_br (
      .i_opcode    (w_opcode),
      .i_imm       (r_ir[IMM_W-1:0]),
      .i_zero_flag (bus.zero_flag),
      .o_pc_incr   (w_incr),
      .o_is_halt   (w_is_halt)
   );

   // Next-state and load enables; waits are flagged as stalls for the watchdog.
   always_comb begin
      w_state_nxt = r_state;
      w_ld_ir     = 1'b0;
      w_ld_incr   = 1'b0;
      w_stall     = 1'b0;
      case (r_state)
         PH_FETCH: begin
            if (bus.imem_valid) begin
               w_state_nxt = PH_DECODE;
               w_ld_ir     = 1'b1;
            end else begin
               w_stall = 1'b1;
            end
         end
         PH_DECODE: w_state_nxt = PH_EXEC;
         PH_EXEC: begin
            if (bus.ex_done) begin
               if (w_is_halt) begin
                  w_state_nxt = PH_HALTED;
               end else begin
                  w_state_nxt = PH_UPDATE;
                  w_ld_incr   = 1'b1;
               end
            end else begin
               w_stall = 1'b1;
            end
         end
         PH_UPDATE: w_state_nxt = PH_FETCH;
         PH_HALTED: w_state_nxt = PH_HALTED;
         default:   w_state_nxt = PH_FETCH;
      endcase
      if (w_wdog_trip) w_state_nxt = PH_HALTED;
   end

   // State, instruction register and increment register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= PH_FETCH;
         r_ir      <= 8'd0;
         r_pc_incr <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         if (w_ld_ir) r_ir <= bus.instr;
         if (w_state_nxt == PH_HALTED) r_pc_incr <= 8'd0;
         else if (w_ld_incr)           r_pc_incr <= w_incr;
      end
   end

`ifdef SIMPLE_PHASE_CTRL_WDOG_EN
   localparam int WD_W = $clog2(WDOG_LIMIT + 1);

   logic [WD_W-1:0] r_wdog_cnt;
   logic            r_wdog_err;

   // Trip on the WDOG_LIMIT-th consecutive waiting cycle.
   assign w_wdog_trip = w_stall && (r_wdog_cnt == WD_W'(WDOG_LIMIT - 1));

   // Consecutive-stall counter; any advance clears it, a trip latches the error.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wdog_cnt <= '0;
         r_wdog_err <= 1'b0;
      end else begin
         if (w_wdog_trip) r_wdog_err <= 1'b1;
         if (w_stall && !w_wdog_trip) r_wdog_cnt <= r_wdog_cnt + 1'b1;
         else                         r_wdog_cnt <= '0;
      end
   end

   assign bus.wdog_err = r_wdog_err;
`else
   // Stalls are unbounded in this build.
   assign w_wdog_trip  = 1'b0;
   assign bus.wdog_err = 1'b0;

   logic w_unused;
   assign w_unused = w_stall;

   if (WDOG_LIMIT < 1) begin : g_bad_limit
   end
`endif

   assign bus.phase   = r_state[1:0];
   assign bus.halted  = (r_state == PH_HALTED);
   assign bus.pc_incr = r_pc_incr;
   assign bus.ir      = r_ir;

endmodule

// File: tb/tb_simple_phase_ctrl.sv
// Self-checking bench for simple_phase_ctrl: directed vector table,
// hand-written corner sequences and randomized stall/opcode traffic
// checked against an opcode-level reference model.
module tb_simple_phase_ctrl;

   logic clk = 1'b0;
   logic reset;

   simple_phase_ctrl_if bus();

   simple_phase_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] last_incr;
   logic [7:0] last_ir;

   typedef struct {
      logic [7:0] ins;
      logic       z;
      logic [7:0] exp_incr;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_inputs();
      bus.imem_valid = 1'($urandom);
      bus.instr      = 8'($urandom);
      bus.ex_done    = 1'($urandom);
      bus.zero_flag  = 1'($urandom);
   endtask

   // Opcode-level model: PC step from the instruction word and zero flag.
   function automatic logic [7:0] ref_incr(input logic [7:0] ins, input logic z);
      int op, v;
      op = int'(ins) / 32;
      v  = int'(ins) % 32;
      if (v >= 16) v = v - 32;
      case (op)
         4:       return z ? 8'(v) : 8'd1;
         5:       return 8'(v);
         default: return 8'd1;
      endcase
   endfunction

   // One full instruction with f fetch stalls and e exec stalls.
   task automatic run_instr(input logic [7:0] ins, input logic z, input int f,
                            input int e, input logic [7:0] exp);
      for (int i = 0; i < f; i++) begin
         rnd_inputs();
         bus.imem_valid = 1'b0;
         step();
         chk("fetch_wait_phase", bus.phase, 2'b00);
         chk("fetch_wait_ir", bus.ir, last_ir);
         chk("fetch_wait_incr", bus.pc_incr, last_incr);
      end
      rnd_inputs();
      bus.imem_valid = 1'b1;
      bus.instr      = ins;
      step();
      chk("decode_phase", bus.phase, 2'b01);
      chk("ir_latch", bus.ir, ins);
      last_ir = ins;
      rnd_inputs();
      step();
      chk("exec_phase", bus.phase, 2'b10);
      for (int i = 0; i < e; i++) begin
         rnd_inputs();
         bus.ex_done = 1'b0;
         step();
         chk("exec_wait_phase", bus.phase, 2'b10);
         chk("exec_wait_incr", bus.pc_incr, last_incr);
      end
      rnd_inputs();
      bus.ex_done   = 1'b1;
      bus.zero_flag = z;
      step();
      chk("update_phase", bus.phase, 2'b11);
      chk("update_incr", bus.pc_incr, exp);
      chk("update_halted", bus.halted, 1'b0);
      last_incr = exp;
      rnd_inputs();
      step();
      chk("refetch_phase", bus.phase, 2'b00);
      chk("refetch_incr", bus.pc_incr, exp);
      chk("refetch_ir", bus.ir, ins);
   endtask

   task automatic do_reset();
      rnd_inputs();
      reset = 1'b1;
      step();
      step();
      reset     = 1'b0;
      last_incr = 8'd0;
      last_ir   = 8'd0;
   endtask

   initial begin
      tbl[0] = '{8'h20, 1'b0, 8'h01};  // ADD
      tbl[1] = '{8'h9D, 1'b1, 8'hFD};  // BRZ -3 taken
      tbl[2] = '{8'h9D, 1'b0, 8'h01};  // BRZ -3 not taken
      tbl[3] = '{8'hA5, 1'b0, 8'h05};  // JMP +5
      tbl[4] = '{8'h00, 1'b1, 8'h01};  // NOP
      tbl[5] = '{8'hC7, 1'b1, 8'h01};  // reserved acts as NOP
      tbl[6] = '{8'h8F, 1'b1, 8'h0F};  // BRZ +15 (max)
      tbl[7] = '{8'hB0, 1'b0, 8'hF0};  // JMP -16 (min)
      tbl[8] = '{8'h7F, 1'b1, 8'h01};  // LD ignores imm
      tbl[9] = '{8'h5A, 1'b1, 8'h01};  // SUB

      do_reset();
      chk("rst_phase", bus.phase, 2'b00);
      chk("rst_incr", bus.pc_incr, 8'h00);
      chk("rst_ir", bus.ir, 8'h00);
      chk("rst_halted", bus.halted, 1'b0);
      chk("rst_wdog", bus.wdog_err, 1'b0);

      for (int i = 0; i < 10; i++)
         run_instr(tbl[i].ins, tbl[i].z, 0, 0, tbl[i].exp_incr);

      // JMP +5 then three cycles without a valid instruction.
      run_instr(8'hA5, 1'b0, 0, 0, 8'h05);
      run_instr(8'h20, 1'b0, 3, 0, 8'h01);

      // Reset coincident with ex_done in EXEC discards the instruction.
      run_instr(8'hA5, 1'b0, 0, 0, 8'h05);
      rnd_inputs();
      bus.imem_valid = 1'b1;
      bus.instr      = 8'h20;
      step();
      rnd_inputs();
      step();
      chk("pre_rst_exec", bus.phase, 2'b10);
      bus.ex_done = 1'b1;
      reset       = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_exec_phase", bus.phase, 2'b00);
      chk("rst_exec_incr", bus.pc_incr, 8'h00);
      chk("rst_exec_halted", bus.halted, 1'b0);
      last_incr = 8'd0;
      last_ir   = 8'd0;

      // Random opcodes (no HALT) with random stalls.
      for (int n = 0; n < 40; n++) begin
         logic [7:0] ins;
         logic       z;
         ins = {3'($urandom_range(0, 6)), 5'($urandom)};
         z   = 1'($urandom);
         run_instr(ins, z, $urandom_range(0, 5), $urandom_range(0, 5), ref_incr(ins, z));
      end

      // HALT: never presents phase 11, stays put until reset.
      rnd_inputs();
      bus.imem_valid = 1'b1;
      bus.instr      = 8'hE0;
      step();
      rnd_inputs();
      step();
      rnd_inputs();
      bus.ex_done = 1'b1;
      step();
      chk("halt_halted", bus.halted, 1'b1);
      chk("halt_phase", bus.phase, 2'b00);
      chk("halt_incr", bus.pc_incr, 8'h00);
      for (int i = 0; i < 22; i++) begin
         rnd_inputs();
         step();
         chk("halted_phase", bus.phase, 2'b00);
         chk("halted_sticky", bus.halted, 1'b1);
      end

      // Long EXEC stall.
      do_reset();
      chk("post_halt_rst", bus.halted, 1'b0);
      rnd_inputs();
      bus.imem_valid = 1'b1;
      bus.instr      = 8'h00;
      step();
      rnd_inputs();
      step();
      for (int i = 0; i < 15; i++) begin
         rnd_inputs();
         bus.ex_done = 1'b0;
         step();
         chk("stall_phase", bus.phase, 2'b10);
         chk("stall_wdog", bus.wdog_err, 1'b0);
      end
      rnd_inputs();
      bus.ex_done = 1'b0;
      step();
`ifdef SIMPLE_PHASE_CTRL_WDOG_EN
      chk("wdog_err", bus.wdog_err, 1'b1);
      chk("wdog_halted", bus.halted, 1'b1);
      chk("wdog_phase", bus.phase, 2'b00);
      rnd_inputs();
      step();
      chk("wdog_sticky", bus.wdog_err, 1'b1);
`else
      for (int i = 0; i < 30; i++) begin
         rnd_inputs();
         bus.ex_done = 1'b0;
         step();
         chk("nowdog_phase", bus.phase, 2'b10);
         chk("nowdog_err", bus.wdog_err, 1'b0);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
